key_debounce: RTL and testbench
===============================

# key_debounce

Upstream conditioner for the board push-button (active-low `KEY`). It synchronises the raw key into `clk_50M`, rejects contact bounce with a counter-based stability filter, and runs a four-state press/release FSM. The FSM produces a clean debounced level, single-cycle press/release/long-press strobes, and a press-toggled level. The `toggle` output is the clean, clocked replacement for edge-triggering downstream run/reset control directly off the raw key.

## Interface
Parameters:
- `DB_CYCLES`, 1_000_000 — consecutive stable samples required to accept a change (20 ms @ 50 MHz); legal range ≥ 2.
- `LONG_CYCLES`, 50_000_000 — cycles after an accepted press at which `long_press` fires (1 s); legal range ≥ 1.

Ports (one clock; reset is asynchronous and active-low):
- `clk_50M`  input  1  system clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `key_n`  input  1  raw button, 0 = pressed; asynchronous to the clock and bouncy.
- `key_level`  output  1  debounced level, 1 = pressed.
- `press_pulse`  output  1  one-cycle strobe on each accepted press.
- `release_pulse`  output  1  one-cycle strobe on each accepted release.
- `long_press`  output  1  one-cycle strobe, at most once per press.
- `toggle`  output  1  inverts on every `press_pulse`.

## Operation
- **Synchroniser.** `key_n` passes through a 2-FF synchroniser; both flops reset to 1 (released). Its output is `key_s`. The FSM uses only `key_s`.
- **Debounce counter `db_cnt`.** Width `$clog2(DB_CYCLES)`.
- **Hold counter `hold_cnt`.** Width `$clog2(LONG_CYCLES+1)`; saturates at `LONG_CYCLES`.
- **FSM states.** Reset state is IDLE.
  - **IDLE.** `key_s`=0 → PRESS_WAIT, `db_cnt`←0. Otherwise stay.
  - **PRESS_WAIT.** `key_s`=1 → IDLE, no outputs (bounce rejected). `key_s`=0 and `db_cnt`=DB_CYCLES-1 → PRESSED; same edge: `press_pulse`←1, `toggle`←~`toggle`, `hold_cnt`←0. Otherwise `db_cnt`++.
  - **PRESSED.** `key_s`=1 → RELEASE_WAIT, `db_cnt`←0.
  - **RELEASE_WAIT.** `key_s`=0 → PRESSED, no outputs (glitch rejected). `key_s`=1 and `db_cnt`=DB_CYCLES-1 → IDLE, `release_pulse`←1. Otherwise `db_cnt`++.
- **Hold counting.** In PRESSED and RELEASE_WAIT, `hold_cnt` increments each cycle while below `LONG_CYCLES`. It is not cleared by release glitches. `long_press`←1 on the edge where `hold_cnt` becomes `LONG_CYCLES`. If an accepted release happens first, no `long_press` is issued.
- **`key_level`.** Registered; 1 exactly while the state is PRESSED or RELEASE_WAIT.
- **Outputs.** All outputs are registered, so no combinational path runs from `key_n` to any output.
- **Pulse exclusivity.** `press_pulse`, `release_pulse` and `long_press` are never high in the same cycle as each other. Each is high for exactly one cycle.

## Timing
- **Reset values.** `key_level`=0, `press_pulse`=0, `release_pulse`=0, `long_press`=0, `toggle`=0; state IDLE; both counters 0; synchroniser flops 1.
- **Edge numbering.** Let edge 0 be the first `clk_50M` edge that samples `key_n`=0, with `key_n` held low afterwards.
  - `key_s`=0 after edge 1.
  - PRESS_WAIT is entered at edge 2.
  - `press_pulse`, `key_level` and the `toggle` change occur at edge DB_CYCLES+2.
- **Press acceptance.** Requires DB_CYCLES+1 consecutive low `key_s` samples.
- **Release latency.** Symmetric: `release_pulse` and `key_level`→0 occur at edge DB_CYCLES+2 after the first edge sampling `key_n`=1.
- **`long_press` timing.** Occurs exactly LONG_CYCLES edges after the `press_pulse` edge, provided no accepted release occurs in between.
- **Glitch rejection.** A change shorter than DB_CYCLES+1 synchronised samples produces no output change.
- **Reset mid-operation.** All state is cleared immediately and asynchronously, and any strobe in flight is dropped. If the key is still held when `rst_n` deasserts, the press is re-detected and produces one `press_pulse` after the full latency above.
- **Reset deassertion.** Must be synchronised externally to `clk_50M`.

## Test plan
All scenarios use DB_CYCLES=4 and LONG_CYCLES=10.
- **Clean press.** `key_n` 1→0 at edge 0, held low → `press_pulse` high for exactly one cycle after edge 6; `key_level`=1 and `toggle`=1 from edge 6.
- **Press bounce.** `key_n` low for 3 cycles, then high → `press_pulse`=0, `key_level`=0, `toggle`=0 throughout.
- **Long hold.** Press held after `press_pulse` at edge 6 → `long_press` high for one cycle at edge 16; none thereafter while held.
- **Release glitch.** During PRESSED, `key_n` high for 2 cycles, then low again → no `release_pulse`; `key_level` stays 1; `long_press` still fires at edge 16.
- **Two full cycles.** Two full press/release cycles → `press_pulse` ×2, `release_pulse` ×2, each release fired 6 edges after its raw rising edge; `toggle` ends at 0.
- **Reset mid-operation.** `rst_n` asserted low mid-PRESS_WAIT, with `key_n` held low → all outputs 0 at once. After `rst_n` releases, `press_pulse` fires 6 edges after the first edge sampling `key_n`=0.

Source files
------------

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, counter-based bounce filter and a
// press/release FSM producing a clean level, press/release/long-press strobes and a toggle.
`timescale 1ns/1ps
module key_debounce #(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int LONG_CYCLES = 50_000_000
) (
    input  logic clk_50M,
    input  logic rst_n,
    input  logic key_n,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press,
    output logic toggle
);

    localparam int DW = $clog2(DB_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t        state;
    logic [1:0]    sync_reg;
    logic          key_s;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    logic          release_accept;
    logic          hold_en;

    assign key_s = sync_reg[1];

    // A release being accepted this edge wins over a long-press that would land on it.
    assign release_accept = (state == RELEASE_WAIT) && key_s && (db_cnt == DB_LAST);
    assign hold_en        = ((state == PRESSED) || (state == RELEASE_WAIT)) && !release_accept;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], key_n};
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            toggle        <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;

            // Hold time keeps running across rejected release glitches.
            if (hold_en && (hold_cnt != HOLD_MAX)) begin
                hold_cnt <= hold_cnt + HW'(1);
                if (hold_cnt == HOLD_LAST) begin
                    long_press <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (!key_s) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (key_s) begin
                        state <= IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= PRESSED;
                        key_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        toggle      <= ~toggle;
                        hold_cnt    <= '0;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                PRESSED: begin
                    if (key_s) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!key_s) begin
                        state <= PRESSED;
                    end else if (db_cnt == DB_LAST) begin
                        state         <= IDLE;
                        key_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Randomised and directed checks of key_debounce against a run-length reference model.
`timescale 1ns/1ps
module tb_key_debounce;

    localparam int DB   = 4;
    localparam int LONG = 10;

    logic clk_50M = 1'b0;
    logic rst_n   = 1'b0;
    logic key_n   = 1'b1;
    logic key_level, press_pulse, release_pulse, long_press, toggle;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // Reference model state: debounced level flips after DB+1 consecutive disagreeing samples.
    logic [1:0] m_pipe = 2'b11;
    logic m_lvl = 0, m_tog = 0, m_press = 0, m_rel = 0, m_long = 0;
    int   m_run = 0, m_age = 0;

    key_debounce #(.DB_CYCLES(DB), .LONG_CYCLES(LONG)) dut (
        .clk_50M      (clk_50M),
        .rst_n        (rst_n),
        .key_n        (key_n),
        .key_level    (key_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .toggle       (toggle)
    );

    always #5 clk_50M = ~clk_50M;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk_50M) begin
        logic pressed_now;
        if (!rst_n) begin
            m_pipe = 2'b11; m_lvl = 0; m_tog = 0; m_run = 0; m_age = 0;
            m_press = 0; m_rel = 0; m_long = 0;
        end else begin
            pressed_now = !m_pipe[1];
            m_press = 0; m_rel = 0; m_long = 0;
            m_run = (pressed_now != m_lvl) ? m_run + 1 : 0;
            if (m_run == DB + 1) begin
                m_lvl = !m_lvl;
                m_run = 0;
                if (m_lvl) begin
                    m_press = 1; m_tog = !m_tog; m_age = 0;
                end else begin
                    m_rel = 1;
                end
            end else if (m_lvl && m_age < LONG) begin
                m_age++;
                if (m_age == LONG) m_long = 1;
            end
            m_pipe = {m_pipe[0], key_n};
        end
    end

    always @(negedge clk_50M) begin
        if (mon_en) begin
            check_val("key_level", key_level, m_lvl);
            check_val("press_pulse", press_pulse, m_press);
            check_val("release_pulse", release_pulse, m_rel);
            check_val("long_press", long_press, m_long);
            check_val("toggle", toggle, m_tog);
            $display("cyc t=%0t key_n=%0b lvl=%0b p=%0b r=%0b l=%0b tog=%0b",
                     $time, key_n, key_level, press_pulse, release_pulse, long_press, toggle);
        end
    end

    // Advance to the n-th following sample point, then nudge past it for driving.
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_50M);
        #1;
    endtask

    task automatic drive_key(input logic v, input int n);
        key_n = v;
        wait_cyc(n);
    endtask

    initial begin
        int len;
        key_n = 1'b1;
        rst_n = 1'b0;
        #1;
        check_val("reset_level", key_level, 1'b0);
        check_val("reset_toggle", toggle, 1'b0);
        mon_en = 1'b1;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(3);

        // Clean press, then long hold: press at edge 6, long press at edge 16.
        key_n = 1'b0;
        wait_cyc(6);
        check_val("clean_pre", press_pulse, 1'b0);
        wait_cyc(1);
        check_val("clean_press", press_pulse, 1'b1);
        check_val("clean_level", key_level, 1'b1);
        check_val("clean_toggle", toggle, 1'b1);
        wait_cyc(1);
        check_val("clean_once", press_pulse, 1'b0);
        wait_cyc(8);
        check_val("long_pre", long_press, 1'b0);
        wait_cyc(1);
        check_val("long_fire", long_press, 1'b1);
        wait_cyc(1);
        check_val("long_once", long_press, 1'b0);
        wait_cyc(10);
        drive_key(1'b1, 12);

        // Press bounce: too short to be accepted.
        drive_key(1'b0, 3);
        drive_key(1'b1, 12);

        // Release glitch inside PRESSED; long press must still land on edge 16.
        key_n = 1'b0;
        wait_cyc(8);
        drive_key(1'b1, 2);
        key_n = 1'b0;
        wait_cyc(7);
        check_val("glitch_long", long_press, 1'b1);
        check_val("glitch_level", key_level, 1'b1);
        drive_key(1'b0, 5);
        drive_key(1'b1, 12);

        // Two full press/release cycles, then one more so toggle is set before reset.
        repeat (3) begin
            drive_key(1'b0, 15);
            drive_key(1'b1, 15);
        end

        // Reset mid-PRESS_WAIT with the key held; re-detection after release.
        drive_key(1'b0, 4);
        rst_n = 1'b0;
        #1;
        check_val("rst_toggle", toggle, 1'b0);
        check_val("rst_level", key_level, 1'b0);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(6);
        check_val("rst_redetect_pre", press_pulse, 1'b0);
        wait_cyc(1);
        check_val("rst_redetect", press_pulse, 1'b1);
        drive_key(1'b0, 5);
        drive_key(1'b1, 12);

        // Random bouncy key with occasional long holds and resets.
        for (int i = 0; i < 400; i++) begin
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 20) : $urandom_range(1, 7);
            drive_key(1'($urandom_range(0, 1)), len);
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 1'b0;
                wait_cyc($urandom_range(1, 2));
                rst_n = 1'b1;
            end
        end
        drive_key(1'b1, 20);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
